// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter that time-shares one 4-bit magnitude comparator among
// NUM_REQ requesters and returns a registered, ID-tagged result.

module comparator_4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       lower,
   output logic       equal,
   output logic       greater
);
   assign lower   = (a < b);
   assign equal   = (a == b);
   assign greater = (a > b);
endmodule

module cmp_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int CNT_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [4*NUM_REQ-1:0] req_a,
   input  logic [4*NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic                 rsp_lower,
   output logic                 rsp_equal,
   output logic                 rsp_greater,
   output logic                 busy,
   output logic [CNT_W-1:0]     cmp_count
);

   typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

   state_t                   r_state, w_next;
   logic [NUM_REQ-1:0][3:0]  w_a, w_b;
   logic [ID_W-1:0]          r_ptr, r_owner, w_win;
   logic                     w_found, w_hs;
   logic [3:0]               r_op_a, r_op_b;
   logic                     w_lower, w_equal, w_greater;
   logic                     r_rsp_valid, r_rsp_lower, r_rsp_equal, r_rsp_greater;
   logic [ID_W-1:0]          r_rsp_id;
   logic [CNT_W-1:0]         r_cnt;

   assign w_a = req_a;
   assign w_b = req_b;

   // (p + k) mod NUM_REQ without relying on NUM_REQ being a power of two
   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return ID_W'(s);
   endfunction

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && req_valid[wrap_add(r_ptr, k)]) begin
            w_found = 1'b1;
            w_win   = wrap_add(r_ptr, k);
         end
      end
   end

   assign w_hs = (r_state == IDLE) && w_found;

   comparator_4 u_cmp (
      .a       (r_op_a),
      .b       (r_op_b),
      .lower   (w_lower),
      .equal   (w_equal),
      .greater (w_greater)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_hs) w_next = CMP;
         CMP:     w_next = RESP;
         RESP:    if (rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      if (w_hs) req_ready[w_win] = 1'b1;
      busy = (r_state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr   <= '0;
         r_owner <= '0;
         r_op_a  <= '0;
         r_op_b  <= '0;
      end else if (w_hs) begin
         r_op_a  <= w_a[w_win];
         r_op_b  <= w_b[w_win];
         r_owner <= w_win;
         r_ptr   <= wrap_add(w_win, 1);
      end
   end

   // Flags are cleared on acceptance so they read all-zero whenever rsp_valid is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid   <= 1'b0;
         r_rsp_id      <= '0;
         r_rsp_lower   <= 1'b0;
         r_rsp_equal   <= 1'b0;
         r_rsp_greater <= 1'b0;
         r_cnt         <= '0;
      end else if (r_state == CMP) begin
         r_rsp_valid   <= 1'b1;
         r_rsp_id      <= r_owner;
         r_rsp_lower   <= w_lower;
         r_rsp_equal   <= w_equal;
         r_rsp_greater <= w_greater;
      end else if (r_state == RESP && rsp_ready) begin
         r_rsp_valid   <= 1'b0;
         r_rsp_lower   <= 1'b0;
         r_rsp_equal   <= 1'b0;
         r_rsp_greater <= 1'b0;
         r_cnt         <= r_cnt + CNT_W'(1);
      end
   end

   assign rsp_valid   = r_rsp_valid;
   assign rsp_id      = r_rsp_id;
   assign rsp_lower   = r_rsp_lower;
   assign rsp_equal   = r_rsp_equal;
   assign rsp_greater = r_rsp_greater;
   assign cmp_count   = r_cnt;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter: grant order, flags, backpressure,
// counter wrap and reset behaviour.

module tb_cmp_share_arbiter;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [3:0]       req_valid;
   logic [3:0][3:0]  ta, tb_;
   logic [15:0]      req_a, req_b;
   logic [3:0]       req_ready;
   logic             rsp_valid, rsp_ready;
   logic [1:0]       rsp_id;
   logic             rsp_lower, rsp_equal, rsp_greater;
   logic             busy;
   logic [7:0]       cmp_count;

   int n_chk = 0;
   int n_err = 0;
   logic [7:0] exp_cnt;

   assign req_a = ta;
   assign req_b = tb_;

   cmp_share_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_lower  (rsp_lower),
      .rsp_equal  (rsp_equal),
      .rsp_greater(rsp_greater),
      .busy       (busy),
      .cmp_count  (cmp_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] ref_flags(input logic [3:0] a, input logic [3:0] b);
      return {a < b, a == b, a > b};
   endfunction

   // One full transaction for requester id, which must be the current winner.
   // clr removes request bits right after the grant edge.
   task automatic txn(input logic [1:0] id, input logic [3:0] clr, input string tag);
      logic [2:0] e;
      e = ref_flags(ta[id], tb_[id]);
      #1;
      chk({tag, ".ready"}, 32'(req_ready), 32'(4'(1) << id));
      tick();
      req_valid = req_valid & ~clr;
      chk({tag, ".busy_cmp"}, 32'(busy), 32'd1);
      chk({tag, ".ready_cmp"}, 32'(req_ready), 32'd0);
      chk({tag, ".vld_cmp"}, 32'(rsp_valid), 32'd0);
      tick();
      chk({tag, ".vld"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".id"}, 32'(rsp_id), 32'(id));
      chk({tag, ".flags"}, 32'({rsp_lower, rsp_equal, rsp_greater}), 32'(e));
      exp_cnt = exp_cnt + 8'd1;
      tick();
      chk({tag, ".vld_done"}, 32'(rsp_valid), 32'd0);
      chk({tag, ".flags_done"}, 32'({rsp_lower, rsp_equal, rsp_greater}), 32'd0);
      chk({tag, ".count"}, 32'(cmp_count), 32'(exp_cnt));
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; ta = '0; tb_ = '0; rsp_ready = 1'b1;
      exp_cnt = '0;
      #1;
      chk("rst.vld", 32'(rsp_valid), 32'd0);
      chk("rst.ready", 32'(req_ready), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.count", 32'(cmp_count), 32'd0);
      chk("rst.id", 32'(rsp_id), 32'd0);
      chk("rst.flags", 32'({rsp_lower, rsp_equal, rsp_greater}), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("idle.ready", 32'(req_ready), 32'd0);

      // round robin with all four requesters valid: 0,1,2,3,0
      ta[0] = 4'd0; tb_[0] = 4'd2;
      ta[1] = 4'd1; tb_[1] = 4'd2;
      ta[2] = 4'd2; tb_[2] = 4'd2;
      ta[3] = 4'd3; tb_[3] = 4'd2;
      req_valid = 4'hF;
      txn(2'd0, 4'h0, "rr0");
      txn(2'd1, 4'h0, "rr1");
      txn(2'd2, 4'h0, "rr2");
      txn(2'd3, 4'h0, "rr3");
      txn(2'd0, 4'hF, "rr4");

      // single request on 0: 5 vs 3 -> greater
      ta[0] = 4'd5; tb_[0] = 4'd3; req_valid = 4'b0001;
      txn(2'd0, 4'b0001, "single");
      chk("single.flags_hand", 32'(ref_flags(4'd5, 4'd3)), 32'(3'b001));

      // requester 2: lower, equal, greater
      ta[2] = 4'd0;  tb_[2] = 4'd15; req_valid = 4'b0100;
      txn(2'd2, 4'b0100, "r2_lo");
      ta[2] = 4'd15; tb_[2] = 4'd15; req_valid = 4'b0100;
      txn(2'd2, 4'b0100, "r2_eq");
      ta[2] = 4'd15; tb_[2] = 4'd0;  req_valid = 4'b0100;
      txn(2'd2, 4'b0100, "r2_gt");

      // move pointer to 2, then 1,2,3 pending -> 2, 3, 1
      ta[1] = 4'd7; tb_[1] = 4'd8; req_valid = 4'b0010;
      txn(2'd1, 4'b0010, "prep");
      ta[3] = 4'd4; tb_[3] = 4'd4;
      req_valid = 4'b1110;
      txn(2'd2, 4'b0100, "fair2");
      txn(2'd3, 4'b1000, "fair3");
      txn(2'd1, 4'b0010, "fair1");

      // backpressure in RESP with other requesters pending
      ta[0] = 4'd9; tb_[0] = 4'd9; req_valid = 4'b0001;
      #1;
      chk("bp.ready", 32'(req_ready), 32'b0001);
      tick();
      req_valid = 4'b1110;
      rsp_ready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp.vld", 32'(rsp_valid), 32'd1);
         chk("bp.id", 32'(rsp_id), 32'd0);
         chk("bp.flags", 32'({rsp_lower, rsp_equal, rsp_greater}), 32'(3'b010));
         chk("bp.ready_hold", 32'(req_ready), 32'd0);
         chk("bp.count", 32'(cmp_count), 32'(exp_cnt));
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      req_valid = '0;
      exp_cnt = exp_cnt + 8'd1;
      chk("bp.vld_done", 32'(rsp_valid), 32'd0);
      chk("bp.count_done", 32'(cmp_count), 32'(exp_cnt));

      // exhaustive on requester 1 from a fresh reset: counter wraps back to 0
      rst_n = 1'b0;
      #1;
      chk("rst2.count", 32'(cmp_count), 32'd0);
      tick();
      rst_n = 1'b1;
      exp_cnt = '0;
      tick();
      for (int i = 0; i < 256; i++) begin
         ta[1] = 4'(i >> 4); tb_[1] = 4'(i);
         req_valid = 4'b0010;
         txn(2'd1, 4'b0010, "exh");
      end
      chk("exh.wrap", 32'(cmp_count), 32'd0);

      // reset during CMP discards the request
      ta[0] = 4'd1; tb_[0] = 4'd2; req_valid = 4'b0001;
      #1;
      chk("rcmp.ready", 32'(req_ready), 32'b0001);
      tick();
      req_valid = '0;
      chk("rcmp.busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rcmp.vld", 32'(rsp_valid), 32'd0);
      chk("rcmp.busy", 32'(busy), 32'd0);
      chk("rcmp.ready0", 32'(req_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      tick(); tick();
      chk("rcmp.no_rsp", 32'(rsp_valid), 32'd0);
      ta[3] = 4'd2; tb_[3] = 4'd11; req_valid = 4'b1000;
      exp_cnt = '0;
      txn(2'd3, 4'b1000, "rcmp.g3");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
